wowa_sweep_gen: RTL and testbench

Digital sweep generator that drives the control input of the analog wah filter in the wowa project. It produces an 8-bit filter-position word from a triangle or sawtooth LFO, or passes a manual pedal value straight through. The word is also emitted as a glitch-free PWM signal, which is RC-filtered off-chip into the analog stage's control voltage. Configuration is written through a small register port from the dedicated inputs.

---
 rtl/wowa_sweep_gen.sv | 146 ++++++++++++++
 tb/tb_wowa_sweep_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wowa_sweep_gen.sv
// wowa_sweep_gen -- sweep generator that drives the control input of the wowa analog wah filter.
//
// The design builds an 8-bit filter-position word in one of two ways:
//   - From a triangle or sawtooth LFO. A prescaled tick advances a phase accumulator.
//     The waveform is scaled by DEPTH and shifted by OFFSET, saturating at 0xFF.
//   - From the manual pedal value, passed straight through.
// The word is also encoded as PWM. The duty value only changes at a PWM period boundary,
// so the output never glitches mid-period.
//
// Parameters:
//   PRE_DIV     clk cycles per LFO tick (>= 2)
//   ACC_W       phase accumulator width (>= 10)
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   ena         design enable; low freezes the LFO and silences PWM
//   cfg_addr    register select: 0 RATE, 1 DEPTH, 2 OFFSET, 3 MODE
//   cfg_data    register write data
//   cfg_we      one-cycle write strobe
//   pedal       manual position
//   sweep_out   registered filter-position word
//   pwm_out     PWM encoding of sweep_out
//   wrap_pulse  one-cycle pulse after an accumulator overflow
module wowa_sweep_gen #(
    parameter int PRE_DIV = 256,
    parameter int ACC_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic       cfg_we,
    input  logic [7:0] pedal,
    output logic [7:0] sweep_out,
    output logic       pwm_out,
    output logic       wrap_pulse
);

    localparam int PRE_W = $clog2(PRE_DIV);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    logic [7:0]       rate_q, rate_d;
    logic [7:0]       depth_q, depth_d;
    logic [7:0]       offset_q, offset_d;
    logic [2:0]       mode_q, mode_d;     // bit0 manual, bit1 hold, bit2 saw
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       sweep_q, sweep_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       duty_q, duty_d;
    logic             pwm_q, pwm_d;

    logic             tick;
    logic             advance;
    logic [SUM_W-1:0] acc_sum;
    logic [7:0]       shape;
    logic [15:0]      prod;
    logic [8:0]       level;

    always_comb begin
        tick    = ena && (pre_q == PRE_LAST);
        advance = tick && !mode_q[1];
        acc_sum = {1'b0, acc_q} + SUM_W'(rate_q);

        // Triangle folds the upper half of the phase back down.
        if (mode_q[2]) begin
            shape = acc_q[ACC_W-1 -: 8];
        end else if (acc_q[ACC_W-1]) begin
            shape = ~acc_q[ACC_W-2 -: 8];
        end else begin
            shape = acc_q[ACC_W-2 -: 8];
        end

        prod  = {8'd0, shape} * {8'd0, depth_q};
        level = {1'b0, offset_q} + 9'(prod >> 8);

        // Config writes land on this edge; the LFO add below still sees the old RATE.
        rate_d   = rate_q;
        depth_d  = depth_q;
        offset_d = offset_q;
        mode_d   = mode_q;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: rate_d   = cfg_data;
                2'd1: depth_d  = cfg_data;
                2'd2: offset_d = cfg_data;
                default: mode_d = cfg_data[2:0];
            endcase
        end

        pre_d = pre_q;
        if (ena) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end

        acc_d  = advance ? acc_sum[ACC_W-1:0] : acc_q;
        wrap_d = advance && acc_sum[ACC_W];

        sweep_d = mode_q[0] ? pedal : sat8(level);

        // Duty is only reloaded at the period boundary so a period is never cut short.
        pwm_cnt_d = ena ? pwm_cnt_q + 8'd1 : 8'd0;
        duty_d    = (pwm_cnt_q == 8'hFF) ? sweep_q : duty_q;
        pwm_d     = ena && (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q    <= 8'h10;
            depth_q   <= 8'hFF;
            offset_q  <= 8'h00;
            mode_q    <= 3'd0;
            pre_q     <= '0;
            acc_q     <= '0;
            wrap_q    <= 1'b0;
            sweep_q   <= 8'd0;
            pwm_cnt_q <= 8'd0;
            duty_q    <= 8'd0;
            pwm_q     <= 1'b0;
        end else begin
            rate_q    <= rate_d;
            depth_q   <= depth_d;
            offset_q  <= offset_d;
            mode_q    <= mode_d;
            pre_q     <= pre_d;
            acc_q     <= acc_d;
            wrap_q    <= wrap_d;
            sweep_q   <= sweep_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
        end
    end

    assign sweep_out  = sweep_q;
    assign pwm_out    = pwm_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_wowa_sweep_gen.sv
// Testbench for wowa_sweep_gen.
// A reference model predicts every cycle's outputs from the behavioural rules and pushes them
// into a queue. A monitor pops that queue on the falling edge and compares. Directed phases
// exercise reset, manual mode, the PWM duty, the wrap period, hold, enable gating and a mid-run
// reset. A randomized phase follows.
module tb_wowa_sweep_gen;

    localparam int PRE_DIV = 4;
    localparam int ACC_W   = 16;
    localparam int ACC_MOD = 1 << ACC_W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_data = 8'd0;
    logic       cfg_we = 1'b0;
    logic [7:0] pedal = 8'd0;
    logic [7:0] sweep_out;
    logic       pwm_out;
    logic       wrap_pulse;

    wowa_sweep_gen #(.PRE_DIV(PRE_DIV), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_we(cfg_we),
        .pedal(pedal),
        .sweep_out(sweep_out), .pwm_out(pwm_out), .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int sweep;
        int pwm;
        int wrap;
    } exp_t;
    exp_t exp_q[$];

    int m_rate = 16, m_depth = 255, m_offset = 0, m_mode = 0;
    int m_pre = 0, m_acc = 0, m_cnt = 0, m_duty = 0, m_sweep = 0, m_pwm = 0, m_wrap = 0;

    function automatic int shape_of(int acc, int mode);
        int p;
        if ((mode & 4) != 0) return acc >> (ACC_W - 8);
        p = (acc >> (ACC_W - 9)) & 511;
        return (p < 256) ? p : 511 - p;
    endfunction

    always @(posedge clk) begin : model
        int tk, adv, sum, n_pre, n_acc, n_wrap, n_sweep, n_duty, n_pwm, n_cnt, lvl;
        exp_t e;
        if (rst) begin
            m_rate = 16; m_depth = 255; m_offset = 0; m_mode = 0;
            m_pre = 0; m_acc = 0; m_cnt = 0; m_duty = 0;
            m_sweep = 0; m_pwm = 0; m_wrap = 0;
        end else begin
            tk     = (ena && m_pre == PRE_DIV - 1) ? 1 : 0;
            n_pre  = ena ? (tk ? 0 : m_pre + 1) : m_pre;
            adv    = (tk && (m_mode & 2) == 0) ? 1 : 0;
            sum    = m_acc + m_rate;
            n_wrap = (adv && sum >= ACC_MOD) ? 1 : 0;
            n_acc  = adv ? sum % ACC_MOD : m_acc;
            if ((m_mode & 1) != 0) begin
                n_sweep = int'(pedal);
            end else begin
                lvl = m_offset + (shape_of(m_acc, m_mode) * m_depth) / 256;
                n_sweep = (lvl > 255) ? 255 : lvl;
            end
            n_duty = (m_cnt == 255) ? m_sweep : m_duty;
            n_pwm  = (ena && m_cnt < m_duty) ? 1 : 0;
            n_cnt  = ena ? (m_cnt + 1) % 256 : 0;
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: m_rate   = int'(cfg_data);
                    2'd1: m_depth  = int'(cfg_data);
                    2'd2: m_offset = int'(cfg_data);
                    default: m_mode = int'(cfg_data) & 7;
                endcase
            end
            m_pre = n_pre; m_acc = n_acc; m_wrap = n_wrap; m_sweep = n_sweep;
            m_duty = n_duty; m_pwm = n_pwm; m_cnt = n_cnt;
        end
        e.sweep = m_sweep;
        e.pwm   = m_pwm;
        e.wrap  = m_wrap;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_sweep_out", 32'(sweep_out), e.sweep);
            check("sb_pwm_out", 32'(pwm_out), e.pwm);
            check("sb_wrap_pulse", 32'(wrap_pulse), e.wrap);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_addr = a;
        cfg_data = d;
        cfg_we   = 1'b1;
        step(1);
        cfg_we   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, hi, found, wraps, changed, held, bad_pwm, bad_wrap;
        logic [7:0] ref_sweep;

        // Reset for three cycles, then release.
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_sweep", 32'(sweep_out), 0);
        check("post_reset_pwm", 32'(pwm_out), 0);
        check("post_reset_wrap", 32'(wrap_pulse), 0);
        step(1);

        // Manual mode: the pedal value reaches the output one edge later.
        wr(2'd3, 8'h01);
        pedal = 8'hA5;
        step(1);
        @(negedge clk);
        check("manual_pedal", 32'(sweep_out), 32'hA5);
        step(600);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) hi++;
        end
        check("pwm_high_count", hi, 165);
        step(1);

        // Wrap period: PRE_DIV=4, RATE=0x80 -> one pulse every 2048 cycles.
        wr(2'd3, 8'h00);
        wr(2'd0, 8'h80);
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (wrap_pulse === 1'b1) found = 1;
        end
        check("first_wrap_seen", found, 1);
        @(negedge clk);
        check("wrap_width", 32'(wrap_pulse), 0);
        n = 1;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            n++;
            if (wrap_pulse === 1'b1) found = 1;
        end
        check("wrap_period", found ? n : -1, 2048);
        step(1);

        // Hold: no wraps and a frozen accumulator (constant triangle output).
        wr(2'd3, 8'h02);
        step(3);
        @(negedge clk);
        ref_sweep = sweep_out;
        wraps = 0;
        changed = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (wrap_pulse !== 1'b0) wraps++;
            if (sweep_out !== ref_sweep) changed++;
        end
        check("hold_wraps", wraps, 0);
        check("hold_sweep_changes", changed, 0);
        step(1);

        // Enable gating: PWM silent, accumulator frozen; resumes afterwards.
        wr(2'd3, 8'h00);
        wr(2'd2, 8'h20);
        step(437);
        ena = 1'b0;
        step(1);
        @(negedge clk);
        check("ena_off_pwm", 32'(pwm_out), 0);
        step(1);
        @(negedge clk);
        ref_sweep = sweep_out;
        bad_pwm = 0;
        bad_wrap = 0;
        held = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pwm_out !== 1'b0) bad_pwm++;
            if (wrap_pulse !== 1'b0) bad_wrap++;
            if (sweep_out !== ref_sweep) held++;
        end
        check("ena_off_pwm_window", bad_pwm, 0);
        check("ena_off_wrap_window", bad_wrap, 0);
        check("ena_off_sweep_held", held, 0);
        step(1);
        ena = 1'b1;
        step(700);

        // Reset in the middle of a PWM period.
        step(123);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        check("midrun_reset_sweep", 32'(sweep_out), 0);
        check("midrun_reset_pwm", 32'(pwm_out), 0);
        check("midrun_reset_wrap", 32'(wrap_pulse), 0);
        step(1);
        rst = 1'b0;

        // Saturating saw: OFFSET=0xC0 with full depth.
        wr(2'd3, 8'h04);
        wr(2'd2, 8'hC0);
        wr(2'd0, 8'hF0);
        step(1500);

        // Randomized phase, checked entirely by the scoreboard.
        for (int i = 0; i < 8000; i++) begin
            rst    = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 249) == 0) ena = ~ena;
            cfg_we   = ($urandom_range(0, 23) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_data = 8'($urandom);
            if ($urandom_range(0, 7) == 0) pedal = 8'($urandom);
            step(1);
        end
        rst = 1'b0;
        cfg_we = 1'b0;
        step(3);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
